// File: rtl/pattern_pkg.sv
// Shared types for the pattern player: FSM states, the 2-bit symbol and its lamp decode.
package pattern_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHOW,
    GAP,
    DONE
  } state_t;

  typedef logic [1:0] symbol_t;

  function automatic logic [3:0] symbol_to_led(input symbol_t sym);
    logic [3:0] led;
    case (sym)
      2'd0:    led = 4'b0001;
      2'd1:    led = 4'b0010;
      2'd2:    led = 4'b0100;
      default: led = 4'b1000;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/symbol_ram.sv
// DEPTH x 2-bit register file holding the stored sequence; synchronous write, asynchronous read.
module symbol_ram
  import pattern_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  symbol_t       wdata,
  input  logic [AW-1:0] raddr,
  output symbol_t       rdata
);

  symbol_t mem [DEPTH];

  // NOTE: storage carries no reset; length bounds every read, so stale entries are never shown.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pattern_player.sv
// Records random 2-bit symbols fetched from an upstream LFSR and plays them back on a one-hot
// lamp, each symbol lit for ON_TICKS prescaler strobes followed by an OFF_TICKS dark gap.
module pattern_player
  import pattern_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 2,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int LEN_W    = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       lfsr_out,
  input  logic             lfsr_valid,
  output logic             lfsr_enable,
  input  logic             append,
  input  logic             play,
  input  logic             clear,
  input  logic             tick,
  output logic [3:0]       led,
  output logic [LEN_W-1:0] length,
  output logic             full,
  output logic             busy,
  output logic             play_done
);

  localparam int CNT_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t           state, state_next;
  logic [IDX_W-1:0] index;
  logic [CNT_W-1:0] tick_cnt;
  symbol_t          rd_sym;
  logic             ram_we;
  logic             on_end, off_end, last_sym;
  logic             unused_lfsr_bits;

  assign unused_lfsr_bits = ^lfsr_out[7:2];

  // Only the low two LFSR bits form a symbol; a write squashed by reset never lands.
  assign ram_we = rst && (state == FETCH) && lfsr_valid;

  symbol_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (length[IDX_W-1:0]),
    .wdata (lfsr_out[1:0]),
    .raddr (index),
    .rdata (rd_sym)
  );

  assign on_end   = tick && (tick_cnt == CNT_W'(ON_TICKS - 1));
  assign off_end  = tick && (tick_cnt == CNT_W'(OFF_TICKS - 1));
  assign last_sym = ({1'b0, index} == (length - LEN_W'(1)));

  assign full        = (length == LEN_W'(DEPTH));
  assign busy        = (state != IDLE);
  assign lfsr_enable = (state == FETCH);
  assign play_done   = (state == DONE);
  assign led         = (state == SHOW) ? symbol_to_led(rd_sym) : 4'b0000;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      length   <= '0;
      index    <= '0;
      tick_cnt <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (clear) begin
            length <= '0;
          end else if (play) begin
            index    <= '0;
            tick_cnt <= '0;
          end
        end
        FETCH: begin
          if (lfsr_valid) length <= length + LEN_W'(1);
        end
        SHOW: begin
          if (on_end)    tick_cnt <= '0;
          else if (tick) tick_cnt <= tick_cnt + CNT_W'(1);
        end
        GAP: begin
          if (off_end) begin
            tick_cnt <= '0;
            if (!last_sym) index <= index + IDX_W'(1);
          end else if (tick) begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state_next is defaulted before the case so no path through this block infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clear)                 state_next = IDLE;
        else if (play)             state_next = (length == '0) ? DONE : SHOW;
        else if (append && !full)  state_next = FETCH;
      end
      FETCH:   if (lfsr_valid) state_next = IDLE;
      SHOW:    if (on_end)     state_next = GAP;
      GAP:     if (off_end)    state_next = last_sym ? DONE : SHOW;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pattern_player.sv
// Directed bench: stimulus pushes expected per-cycle lamp/done values and fetch lengths into queues;
// a negedge monitor pops and compares whenever the player is busy or completes a fetch.
module tb_pattern_player;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lfsr_out;
  logic       lfsr_valid;
  logic       lfsr_enable;
  logic       append, play, clear, tick;
  logic [3:0] led;
  logic [4:0] length;
  logic       full, busy, play_done;

  pattern_player dut (
    .clk         (clk),
    .rst         (rst),
    .lfsr_out    (lfsr_out),
    .lfsr_valid  (lfsr_valid),
    .lfsr_enable (lfsr_enable),
    .append      (append),
    .play        (play),
    .clear       (clear),
    .tick        (tick),
    .led         (led),
    .length      (length),
    .full        (full),
    .busy        (busy),
    .play_done   (play_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] led;
    logic       done;
  } exp_t;

  exp_t       exp_q[$];
  int         len_q[$];
  int         n_pass = 0;
  int         n_total = 0;
  int         en_cycles = 0;
  int         model_len = 0;
  logic [1:0] model_mem [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] lamp(input logic [1:0] s);
    case (s)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // Monitor: every busy non-fetch cycle is a playback output; every accepted fetch is checked.
  always @(negedge clk) begin
    exp_t e;
    if (busy && !lfsr_enable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_busy_out", {27'd0, led, play_done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("led", {28'd0, led}, {28'd0, e.led});
        check("play_done", {31'd0, play_done}, {31'd0, e.done});
      end
    end
    if (lfsr_enable && lfsr_valid && rst) begin
      if (len_q.size() == 0) check("unexpected_fetch", 32'd1, 32'd0);
      else check("fetch_len", {27'd0, length}, len_q.pop_front());
    end
    if (lfsr_enable) en_cycles++;
  end

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] l, input logic d, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{led: l, done: d});
  endtask

  task automatic do_append(input logic [7:0] val, input int delay);
    len_q.push_back(model_len);
    model_mem[model_len] = val[1:0];
    model_len++;
    append = 1'b1;
    cycle(1);
    append = 1'b0;
    cycle(delay - 1);
    lfsr_out   = val;
    lfsr_valid = 1'b1;
    cycle(1);
    lfsr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      cycle(1);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int e0;
    rst = 1'b0; lfsr_out = 8'h00; lfsr_valid = 1'b0;
    append = 1'b0; play = 1'b0; clear = 1'b0; tick = 1'b0;
    cycle(2);
    check("rst_led", {28'd0, led}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_length", {27'd0, length}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_lfsr_enable", {31'd0, lfsr_enable}, 32'd0);
    check("rst_play_done", {31'd0, play_done}, 32'd0);
    rst = 1'b1;
    cycle(1);

    // One append, LFSR answers in the third FETCH cycle.
    e0 = en_cycles;
    do_append(8'hD3, 3);
    check("fetch_enable_cycles", en_cycles - e0, 3);
    check("len_after_1", {27'd0, length}, 32'd1);
    check("busy_after_fetch", {31'd0, busy}, 32'd0);

    // Three-symbol playback with tick every cycle; requests during playback are ignored.
    do_append(8'h12, 1);
    do_append(8'h00, 2);
    check("len_after_3", {27'd0, length}, 32'd3);
    push_exp(4'b1000, 1'b0, 4); push_exp(4'b0000, 1'b0, 2);
    push_exp(4'b0100, 1'b0, 4); push_exp(4'b0000, 1'b0, 2);
    push_exp(4'b0001, 1'b0, 4); push_exp(4'b0000, 1'b0, 2);
    push_exp(4'b0000, 1'b1, 1);
    e0 = en_cycles;
    tick = 1'b1; play = 1'b1;
    cycle(1);
    play = 1'b0;
    cycle(4);
    play = 1'b1; append = 1'b1; clear = 1'b1;
    cycle(1);
    play = 1'b0; append = 1'b0; clear = 1'b0;
    wait_idle(100);
    tick = 1'b0;
    check("len_kept_after_play", {27'd0, length}, 32'd3);
    check("no_fetch_while_busy", en_cycles - e0, 0);
    check("led_dark_idle", {28'd0, led}, 32'd0);

    // clear beats play and append in the same IDLE cycle.
    e0 = en_cycles;
    clear = 1'b1; play = 1'b1; append = 1'b1;
    cycle(1);
    clear = 1'b0; play = 1'b0; append = 1'b0;
    model_len = 0;
    check("clear_length", {27'd0, length}, 32'd0);
    check("clear_busy", {31'd0, busy}, 32'd0);
    cycle(2);
    check("clear_no_fetch", en_cycles - e0, 0);
    check("clear_still_idle", {31'd0, busy}, 32'd0);

    // Play on an empty sequence goes straight to DONE.
    push_exp(4'b0000, 1'b1, 1);
    play = 1'b1;
    cycle(1);
    play = 1'b0;
    wait_idle(10);

    // Single symbol with two tick-less cycles at the start of SHOW.
    do_append(8'h01, 1);
    push_exp(4'b0010, 1'b0, 6); push_exp(4'b0000, 1'b0, 2); push_exp(4'b0000, 1'b1, 1);
    play = 1'b1;
    cycle(1);
    play = 1'b0;
    cycle(2);
    tick = 1'b1;
    wait_idle(50);
    tick = 1'b0;
    check("len_after_slow_play", {27'd0, length}, 32'd1);

    // Reset while lit aborts without play_done.
    push_exp(lamp(model_mem[0]), 1'b0, 3);
    play = 1'b1;
    cycle(1);
    play = 1'b0;
    cycle(2);
    rst = 1'b0;
    cycle(1);
    model_len = 0;
    check("rst_show_led", {28'd0, led}, 32'd0);
    check("rst_show_busy", {31'd0, busy}, 32'd0);
    check("rst_show_length", {27'd0, length}, 32'd0);
    rst = 1'b1;
    cycle(3);

    // Reset mid-FETCH discards a coincident lfsr_valid.
    append = 1'b1;
    cycle(1);
    append = 1'b0;
    lfsr_out = 8'hFF; lfsr_valid = 1'b1; rst = 1'b0;
    cycle(1);
    lfsr_valid = 1'b0; rst = 1'b1;
    check("rst_fetch_length", {27'd0, length}, 32'd0);
    check("rst_fetch_enable", {31'd0, lfsr_enable}, 32'd0);
    check("rst_fetch_busy", {31'd0, busy}, 32'd0);

    // Fill to DEPTH, then an extra append is ignored.
    for (int i = 0; i < 16; i++) do_append(8'(i * 37 + 5), 1 + (i % 3));
    check("full_flag", {31'd0, full}, 32'd1);
    check("full_length", {27'd0, length}, 32'd16);
    e0 = en_cycles;
    append = 1'b1;
    cycle(1);
    append = 1'b0;
    check("overfill_busy", {31'd0, busy}, 32'd0);
    check("overfill_enable", {31'd0, lfsr_enable}, 32'd0);
    cycle(3);
    check("overfill_no_fetch", en_cycles - e0, 0);
    check("overfill_length", {27'd0, length}, 32'd16);

    check("exp_queue_drained", exp_q.size(), 0);
    check("fetch_queue_drained", len_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
